multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control unit for the multicycle RV32I datapath; drives the ALU's 4-bit ALUControl and consumes its 4-bit Flags.
- Moore main FSM sequences fetch/decode/execute/memory/writeback; a combinational ALU decoder maps ALUOp/funct3/funct7b5 to ALUControl.
- Sits between the instruction register and the datapath muxes/enables; handshakes with unified instruction/data memory via mem_ready.

Parameters:
- XLEN, 32, datapath width; informational, used only for assertions.
- ILLEGAL_TRAP, 1, 1 = illegal opcode pulses illegal and returns to FETCH; 0 = treat it as a NOP.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- op  in  7  instruction[6:0] from IR.
- funct3  in  3  instruction[14:12].
- funct7b5  in  1  instruction[30].
- Flags  in  4  ALU flags {Negative, Zero, Carry, Overflow}.
- mem_ready  in  1  memory has completed the current access.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR and OldPC enable.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4.
- ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- RegWrite  out  1  register file write enable.
- ALUControl  out  4  operation code to the ALU.
- illegal  out  1  one-cycle pulse on an undecodable opcode.

Behaviour:
- Reset: state = FETCH. While reset is high, PCWrite, IRWrite, MemWrite, RegWrite and illegal are forced to 0 combinationally, including mid-operation. All other outputs take their FETCH values.
- ALUControl encoding (fixed, shared with the ALU):
  - ADD 0000, SUB 0001, AND 0010, OR 0011, SLT 0101, SLL 0110, SRL 0111.
  - XOR 1000, SLTU 1001, SRA 1010, LUI 1011, AUIPC 1100.
- ALU decoder, driven by ALUOp:
  - ALUOp 00 -> ADD; 01 -> SUB.
  - ALUOp 10 (funct3): 000 -> SUB if op[5] & funct7b5, else ADD; 001 -> SLL; 010 -> SLT; 011 -> SLTU; 100 -> XOR; 101 -> SRA if funct7b5, else SRL; 110 -> OR; 111 -> AND.
  - ALUOp 11 -> LUI when op = 0110111, AUIPC when op = 0010111.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCWrite = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target); ImmSrc from op.
  - 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI.
  - 1100011 -> BRANCH; 1101111 -> JAL; 0110111 or 0010111 -> UPPER.
  - Any other op -> illegal=1 for this cycle, next state FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1. Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 while waiting. Hold until mem_ready, then FETCH. MemWrite deasserts the cycle after mem_ready.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- UPPER: ALUSrcA=01, ALUSrcB=01, ImmSrc=100, ALUOp=11 -> ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite = taken; next state FETCH.
  - BEQ taken = Flags[2]; BNE taken = ~Flags[2].
  - BLT taken = Flags[3]^Flags[0]; BGE taken = ~(Flags[3]^Flags[0]).
  - Any other funct3 -> taken=0.
- Latency with mem_ready=1 every cycle: R/I/U-type 4 cycles; load 5; store 4; branch 3; JAL 4. Every wait cycle adds exactly 1.
- mem_ready is ignored in every state other than FETCH, MEMREAD and MEMWRITE.
- Unused outputs in a state are driven 0, never X.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - alu_ctrl_t enum with the encodings above.
  - statetype enum.
  - Opcode localparams: OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC.
  - ALUOp, ImmSrc and ResultSrc constants.
- One sub-module, alu_decoder (ALUOp, funct3, funct7b5, op[5] -> ALUControl), instantiated in multicycle_controller.

Test Plan:
- SUB R-type (op=0110011, funct3=000, funct7b5=1), mem_ready=1 -> states FETCH, DECODE, EXECUTER, ALUWB; ALUControl=0001 in EXECUTER; RegWrite=1 only in ALUWB.
- BEQ (op=1100011, funct3=000): with Flags=0100, PCWrite=1 in BRANCH; repeat with Flags=0000, PCWrite=0; BLT with Flags=1000 -> PCWrite=1.
- LW (op=0000011) with mem_ready held 0 for 3 cycles in MEMREAD -> stays in MEMREAD 4 cycles total, AdrSrc=1 throughout, then MEMWB with ResultSrc=01 and RegWrite=1.
- SW, with reset asserted in the second MEMWRITE cycle -> MemWrite=0 in the same cycle; state is FETCH after reset release.
- op=1111111 -> illegal=1 for exactly the DECODE cycle; next state FETCH; no enable asserted.
- SRAI (op=0010011, funct3=101, funct7b5=1) -> ALUControl=1010; LUI -> ImmSrc=100 and ALUControl=1011 in UPPER.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the multicycle RV32I control unit
package riscv_ctrl_pkg;
  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_SLT   = 4'b0101,
    ALU_SLL   = 4'b0110,
    ALU_SRL   = 4'b0111,
    ALU_XOR   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_SRA   = 4'b1010,
    ALU_LUI   = 4'b1011,
    ALU_AUIPC = 4'b1100
  } alu_ctrl_t;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_UPPER, S_JAL, S_BRANCH
  } statetype;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_UPPER = 2'b11;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  function automatic logic [2:0] imm_src(input logic [6:0] op);
    return op == OP_STORE ? IMM_S : op == OP_BRANCH ? IMM_B : op == OP_JAL ? IMM_J :
           (op == OP_LUI || op == OP_AUIPC) ? IMM_U : IMM_I;
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp/funct3/funct7b5/op[5] onto the ALU operation code
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [3:0] alu_control_o
);
  alu_ctrl_t funct_ctrl;
  always_comb begin
    funct_ctrl = ALU_ADD;
    case (funct3_i)
      3'b000: funct_ctrl = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b001: funct_ctrl = ALU_SLL;
      3'b010: funct_ctrl = ALU_SLT;
      3'b011: funct_ctrl = ALU_SLTU;
      3'b100: funct_ctrl = ALU_XOR;
      3'b101: funct_ctrl = funct7b5_i ? ALU_SRA : ALU_SRL;
      3'b110: funct_ctrl = ALU_OR;
      3'b111: funct_ctrl = ALU_AND;
    endcase
  end
  // op[5] alone separates LUI (0110111) from AUIPC (0010111)
  assign alu_control_o = alu_op_i == ALUOP_ADD ? ALU_ADD : alu_op_i == ALUOP_SUB ? ALU_SUB :
                         alu_op_i == ALUOP_FUNCT ? funct_ctrl : op5_i ? ALU_LUI : ALU_AUIPC;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the multicycle RV32I datapath
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [3:0] Flags,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic [3:0] ALUControl,
  output logic       illegal
);
  statetype state_q, state_d;
  logic [1:0] alu_op;
  logic pc_write, ir_write, mem_write, reg_write, ill, legal, lt, taken, unused_carry;
  if (XLEN != 32) begin : g_xlen
    $error("multicycle_controller only supports XLEN=32");
  end
  assign unused_carry = Flags[1];
  assign legal = op inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC};
  assign lt = Flags[3] ^ Flags[0];
  assign taken = funct3 == 3'b000 ? Flags[2] : funct3 == 3'b001 ? ~Flags[2] :
                 funct3 == 3'b100 ? lt : funct3 == 3'b101 ? ~lt : 1'b0;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= S_FETCH;
    else state_q <= state_d;
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = (op == OP_LOAD || op == OP_STORE) ? S_MEMADR : op == OP_R ? S_EXECUTER :
                            op == OP_I ? S_EXECUTEI : op == OP_BRANCH ? S_BRANCH : op == OP_JAL ? S_JAL :
                            (op == OP_LUI || op == OP_AUIPC) ? S_UPPER : S_FETCH;
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER, S_EXECUTEI, S_UPPER, S_JAL: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end
  always_comb begin
    pc_write = 1'b0;
    AdrSrc = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA = SRCA_PC;
    ALUSrcB = SRCB_RD2;
    ImmSrc = IMM_I;
    reg_write = 1'b0;
    alu_op = ALUOP_ADD;
    ill = 1'b0;
    case (state_q)
      S_FETCH: begin
        ResultSrc = RES_ALURESULT;
        ALUSrcB = SRCB_FOUR;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc = imm_src(op);
        ill = ILLEGAL_TRAP && !legal;
      end
      S_MEMADR, S_EXECUTEI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ImmSrc = imm_src(op);
        alu_op = state_q == S_EXECUTEI ? ALUOP_FUNCT : ALUOP_ADD;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_write = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RD1;
        alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_UPPER: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc = IMM_U;
        alu_op = ALUOP_UPPER;
      end
      // ALUOut still holds PC+imm from DECODE; this cycle forms the link value
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        pc_write = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RD1;
        alu_op = ALUOP_SUB;
        pc_write = taken;
      end
      default: ;
    endcase
  end
  alu_decoder u_alu_decoder (
    .alu_op_i     (alu_op),
    .funct3_i     (funct3),
    .funct7b5_i   (funct7b5),
    .op5_i        (op[5]),
    .alu_control_o(ALUControl)
  );
  assign PCWrite  = pc_write & ~reset;
  assign IRWrite  = ir_write & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign illegal  = ill & ~reset;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-instruction expected control traces checked cycle by cycle
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset, funct7b5, mem_ready;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [3:0] Flags;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl;
  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Flags(Flags), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
    .illegal(illegal)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [18:0] exp_q[$], mask_q[$], obs_q[$];
  logic mr_q[$];
  localparam logic [18:0] ALL = '1;
  localparam logic [18:0] NOIMM = 19'h7FE3F;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, LU = 7'b0110111, AU = 7'b0010111;
  localparam logic [3:0] FUNCT_ALU [8] = '{4'b0000, 4'b0110, 4'b0101, 4'b1001, 4'b1000, 4'b0111, 4'b0011, 4'b0010};
  localparam logic [6:0] OPS [10] = '{LD, ST, RT, IT, BR, JL, LU, AU, 7'b1111111, 7'b0000000};
  function automatic logic [18:0] ctl(input int pcw, adr, mw, irw, rs, a, b, imm, rw, alu, ill);
    return {pcw[0], adr[0], mw[0], irw[0], rs[1:0], a[1:0], b[1:0], imm[2:0], rw[0], alu[3:0], ill[0]};
  endfunction
  function automatic logic [18:0] observed();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegWrite, ALUControl, illegal};
  endfunction
  function automatic logic rnd();
    return 1'($urandom_range(1));
  endfunction
  function automatic int ref_alu(input logic rtype, input logic [2:0] f3, input logic f7);
    if (f3 == 3'd0 && rtype && f7) return 1;
    if (f3 == 3'd5 && f7) return 10;
    return int'(FUNCT_ALU[f3]);
  endfunction
  task automatic push(input logic [18:0] w, input logic [18:0] m, input logic mr);
    exp_q.push_back(w & m);
    mask_q.push_back(m);
    mr_q.push_back(mr);
  endtask
  // Expected trace of one instruction: fw FETCH stalls, mw stalls in the memory state
  task automatic plan(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [3:0] fl, input int fw, input int mw);
    logic lt, tk, legal;
    int imm;
    exp_q.delete();
    mask_q.delete();
    mr_q.delete();
    repeat (fw) push(ctl(0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0), ALL, 1'b0);
    push(ctl(1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0), ALL, 1'b1);
    legal = o inside {LD, ST, RT, IT, BR, JL, LU, AU};
    imm = o == ST ? 1 : o == BR ? 2 : o == JL ? 3 : (o == LU || o == AU) ? 4 : 0;
    push(ctl(0, 0, 0, 0, 0, 1, 1, imm, 0, 0, !legal), ALL, rnd());
    if (o == LD || o == ST) begin
      push(ctl(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0), NOIMM, rnd());
      repeat (mw) push(ctl(0, 1, o == ST, 0, 0, 0, 0, 0, 0, 0, 0), ALL, 1'b0);
      push(ctl(0, 1, o == ST, 0, 0, 0, 0, 0, 0, 0, 0), ALL, 1'b1);
      if (o == LD) push(ctl(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0), ALL, rnd());
    end
    else if (o == RT || o == IT) push(ctl(0, 0, 0, 0, 0, 2, o == IT, 0, 0, ref_alu(o == RT, f3, f7), 0), NOIMM, rnd());
    else if (o == LU || o == AU) push(ctl(0, 0, 0, 0, 0, 1, 1, 4, 0, o == LU ? 11 : 12, 0), ALL, rnd());
    else if (o == JL) push(ctl(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0), ALL, rnd());
    else if (o == BR) begin
      lt = fl[3] ^ fl[0];
      tk = f3 == 3'd0 ? fl[2] : f3 == 3'd1 ? !fl[2] : f3 == 3'd4 ? lt : f3 == 3'd5 ? !lt : 1'b0;
      push(ctl(tk, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0), ALL, rnd());
    end
    if (o inside {RT, IT, LU, AU, JL}) push(ctl(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ALL, rnd());
  endtask
  task automatic run(input int n);
    obs_q.delete();
    for (int i = 0; i < n; i++) begin
      mem_ready = mr_q[i];
      @(negedge clk);
      obs_q.push_back(observed() & mask_q[i]);
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [3:0] fl, input int fw, input int mw);
    op = o;
    funct3 = f3;
    funct7b5 = f7;
    Flags = fl;
    plan(o, f3, f7, fl, fw, mw);
    run(exp_q.size());
  endtask
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    op = RT;
    funct3 = 3'd0;
    funct7b5 = 1'b1;
    Flags = 4'b0100;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (observed() !== ctl(0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0)) begin
        errors++;
        $display("FAIL reset got %h exp %h", observed(), ctl(0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0));
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  task automatic test_rtype_sub();
    drive(RT, 3'd0, 1'b1, 4'd0, 0, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL sub cycle %0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask
  task automatic test_branch();
    logic [2:0] f3s [6] = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [3:0] fls [6] = '{4'b0100, 4'b0000, 4'b1000, 4'b0100, 4'b1001, 4'b0100};
    for (int t = 0; t < 6; t++) begin
      drive(BR, f3s[t], 1'b0, fls[t], 0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL branch%0d cycle %0d got %h exp %h", t, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask
  task automatic test_load_wait();
    for (int t = 0; t < 2; t++) begin
      drive(LD, 3'd2, 1'b0, 4'd0, t * 2, 3 - t * 3);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL load%0d cycle %0d got %h exp %h", t, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask
  task automatic test_store_reset();
    drive(ST, 3'd2, 1'b0, 4'd0, 0, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL store cycle %0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    plan(ST, 3'd2, 1'b0, 4'd0, 0, 3);
    run(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL store_rst cycle %0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    mem_ready = 1'b0;
    #1;
    checks++;
    if ({MemWrite, AdrSrc} !== 2'b11) begin
      errors++;
      $display("FAIL store_wait2 got %b exp 11", {MemWrite, AdrSrc});
    end
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (observed() !== ctl(0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL store_in_reset got %h exp %h", observed(), ctl(0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0));
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (observed() !== ctl(1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0)) begin
      errors++;
      $display("FAIL store_after_reset got %h exp %h", observed(), ctl(1, 0, 0, 1, 2, 0, 2, 0, 0, 0, 0));
    end
    @(posedge clk);
    #1;
    do_reset();
  endtask
  task automatic test_illegal();
    logic [6:0] ops [2] = '{7'b1111111, RT};
    for (int t = 0; t < 2; t++) begin
      drive(ops[t], 3'd0, 1'b0, 4'd0, 0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL illegal%0d cycle %0d got %h exp %h", t, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask
  task automatic test_srai_lui();
    logic [6:0] ops [6] = '{IT, LU, AU, RT, RT, IT};
    logic [2:0] f3s [6] = '{3'd5, 3'd0, 3'd0, 3'd5, 3'd0, 3'd0};
    logic f7s [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int t = 0; t < 6; t++) begin
      drive(ops[t], f3s[t], f7s[t], 4'd0, 0, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL alu%0d cycle %0d got %h exp %h", t, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask
  task automatic test_back_to_back();
    for (int t = 0; t < 60; t++) begin
      logic [6:0] o;
      o = OPS[$urandom_range(9)];
      if (o == 7'b0000000) o = 7'($urandom);
      drive(o, 3'($urandom), rnd(), 4'($urandom), $urandom_range(2), $urandom_range(3));
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand%0d op %b cycle %0d got %h exp %h", t, o, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_rtype_sub();
    test_branch();
    test_load_wait();
    test_store_reset();
    test_illegal();
    test_srai_lui();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
